// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester and memory bus bundle for the data-memory arbiter
interface dmem_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              req0, req1, we0, we1, ack0, ack1, err0, err1, mem_we;
  logic [ADDR_W-1:0] addr0, addr1, mem_addr;
  logic [DATA_W-1:0] wdata0, wdata1, rdata0, rdata1, mem_wdata, mem_rdata;
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, err0, err1, rdata0, rdata1, mem_addr, mem_wdata, mem_we
  );
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, err0, err1, rdata0, rdata1, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port req/ack sequencer for the single-ported data memory
// DMEM_ARB_RR_EN selects round-robin tie-breaking; otherwise port 0 has fixed priority.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic clk,
  input logic rst,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic gnt, gnt_nx, bad, any_req, sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  assign any_req = bus.req0 | bus.req1;
`ifdef DMEM_ARB_RR_EN
  logic last;
  assign gnt_nx = bus.req1 & (~bus.req0 | ~last);
  // last starts at 1 so that port 0 takes the first tie
  always_ff @(posedge clk or posedge rst)
    if (rst) last <= 1'b1;
    else if (state == IDLE && any_req) last <= gnt_nx;
`else
  assign gnt_nx = bus.req1 & ~bus.req0;
`endif
  always_comb begin
    sel_addr  = gnt_nx ? bus.addr1 : bus.addr0;
    sel_wdata = gnt_nx ? bus.wdata1 : bus.wdata0;
    sel_we    = gnt_nx ? bus.we1 : bus.we0;
    state_nx  = state == IDLE ? (any_req ? ACCESS : IDLE) : state == ACCESS ? RESP : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // async reset clears mem_we at once so an abandoned write never lands
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      gnt           <= 1'b0;
      bad           <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_we    <= 1'b0;
      bus.ack0      <= 1'b0;
      bus.ack1      <= 1'b0;
      bus.err0      <= 1'b0;
      bus.err1      <= 1'b0;
      bus.rdata0    <= '0;
      bus.rdata1    <= '0;
    end else begin
      bus.ack0 <= 1'b0;
      bus.ack1 <= 1'b0;
      bus.err0 <= 1'b0;
      bus.err1 <= 1'b0;
      if (state == IDLE && any_req) begin
        gnt           <= gnt_nx;
        bad           <= |sel_addr[1:0];
        bus.mem_addr  <= sel_addr;
        bus.mem_wdata <= sel_wdata;
        bus.mem_we    <= sel_we & ~|sel_addr[1:0];
      end else if (state == ACCESS) begin
        bus.mem_we <= 1'b0;
      end else if (state == RESP) begin
        if (gnt) begin
          bus.ack1   <= 1'b1;
          bus.err1   <= bad;
          bus.rdata1 <= bad ? '0 : bus.mem_rdata;
        end else begin
          bus.ack0   <= 1'b1;
          bus.err0   <= bad;
          bus.rdata0 <= bad ? '0 : bus.mem_rdata;
        end
      end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter against a 1024x32 write-first memory model
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  logic [31:0] mem [0:1023];
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
    bus.mem_rdata <= bus.mem_we ? bus.mem_wdata : mem[bus.mem_addr[11:2]];
    if (bus.mem_we) we_cnt <= we_cnt + 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic xfer(input bit p, input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic e, output int lat);
    if (p) begin
      bus.req1 = 1'b1; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
    end else begin
      bus.req0 = 1'b1; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
    end
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!(p ? bus.ack1 : bus.ack0) && lat < 10);
    rd = p ? bus.rdata1 : bus.rdata0;
    e  = p ? bus.err1 : bus.err0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask
  initial begin
    logic [31:0] rd, old;
    logic e, seen;
    int lat, w0, n, cyc;
    logic g [4];
    logic [31:0] r [4];
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", 32'({bus.ack0, bus.ack1, bus.err0, bus.err1}), 0);
    check("rst_rdata", bus.rdata0 | bus.rdata1, 0);
    check("rst_mem", bus.mem_addr | bus.mem_wdata | 32'(bus.mem_we), 0);
    check("rst_state", 32'(dut.state), 0);
    rst = 0;
    @(posedge clk); #1;
    w0 = we_cnt;
    xfer(0, 1, 32'h10, 32'hDEADBEEF, rd, e, lat);
    check("wr_lat", 32'(lat - 1), 2);
    check("wr_echo", rd, 32'hDEADBEEF);
    check("wr_err", 32'(e), 0);
    @(posedge clk); #1;
    check("wr_we_cnt", 32'(we_cnt - w0), 1);
    check("wr_mem", mem[4], 32'hDEADBEEF);
    w0 = we_cnt;
    xfer(0, 0, 32'h10, 32'h0, rd, e, lat);
    check("rd_lat", 32'(lat - 1), 2);
    check("rd_data", rd, 32'hDEADBEEF);
    check("rd_err", 32'(e), 0);
    check("rd_no_we", 32'(we_cnt - w0), 0);
    xfer(0, 1, 32'h0, 32'h000000A0, rd, e, lat);
    xfer(0, 1, 32'h4, 32'h000000B1, rd, e, lat);
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 32'h0;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 32'h4;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 30) begin
      @(posedge clk); #1; cyc++;
      if (bus.ack0 | bus.ack1) begin
        g[n] = bus.ack1;
        r[n] = bus.ack1 ? bus.rdata1 : bus.rdata0;
        n++;
      end
    end
    check("tie_acks", 32'(n), 4);
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
      check("tie_gnt", 32'(g[i]), 32'(i % 2));
      check("tie_data", r[i], (i % 2) ? 32'hB1 : 32'hA0);
`else
      check("tie_gnt", 32'(g[i]), 0);
      check("tie_data", r[i], 32'hA0);
`endif
    end
    bus.req0 = 0;
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (!(bus.ack0 | bus.ack1) && cyc < 10);
    check("p1_after_drop", 32'({bus.ack0, bus.ack1}), 32'b01);
    check("p1_data", bus.rdata1, 32'hB1);
    bus.req1 = 0;
    @(posedge clk); #1;
    w0 = we_cnt;
    xfer(1, 1, 32'h6, 32'h12345678, rd, e, lat);
    check("mis_ack_lat", 32'(lat - 1), 2);
    check("mis_err", 32'(e), 1);
    check("mis_rdata", rd, 0);
    check("mis_no_we", 32'(we_cnt - w0), 0);
    check("mis_mem", mem[1], 32'hB1);
    old = mem[8];
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 32'h20; bus.wdata0 = 32'h55AA55AA;
    @(posedge clk); #1;
    check("rst_mid_we_hi", 32'(bus.mem_we), 1);
    #2 rst = 1;
    #1;
    check("rst_mid_we_lo", 32'(bus.mem_we), 0);
    check("rst_mid_addr", bus.mem_addr | bus.mem_wdata, 0);
    check("rst_mid_state", 32'(dut.state), 0);
    bus.req0 = 0;
    @(posedge clk); #1;
    rst = 0;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      seen |= bus.ack0 | bus.ack1;
    end
    check("rst_mid_no_ack", 32'(seen), 0);
    check("rst_mid_mem", mem[8], old);
    xfer(0, 1, 32'h1010, 32'hCAFEF00D, rd, e, lat);
    check("alias_addr", bus.mem_addr, 32'h1010);
    check("alias_err", 32'(e), 0);
    check("alias_echo", rd, 32'hCAFEF00D);
    @(posedge clk); #1;
    check("alias_mem", mem[4], 32'hCAFEF00D);
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 32'h10;
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (!bus.ack0 && cyc < 10);
    check("b2b_first", 32'(bus.ack0), 1);
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (!bus.ack0 && cyc < 10);
    check("b2b_gap", 32'(cyc), 3);
    check("b2b_data", bus.rdata0, 32'hCAFEF00D);
    bus.req0 = 0;
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the 1024×32 data memory. It lets the CPU MEM stage (port 0) and the DMA/debug loader (port 1) share the single-ported memory. Requests use a req/ack handshake, and the block drives the memory's address, write-data and write-enable. Word-aligned accesses only; a misaligned request is acknowledged with an error and never touches memory.

## Interface
Parameters:
- ADDR_W, 32, width of requester and memory address buses
- DATA_W, 32, width of data buses

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req0 / req1  in  1  access request, port 0 / port 1
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  byte address; bits [1:0] must be 00
- wdata0 / wdata1  in  DATA_W  write data
- ack0 / ack1  out  1  one-cycle completion pulse
- err0 / err1  out  1  misaligned flag, valid only with ack
- rdata0 / rdata1  out  DATA_W  read data (write data echo on writes), valid with ack, held until next ack on that port
- mem_addr  out  ADDR_W  memory address (memory decodes [11:2])
- mem_wdata  out  DATA_W  memory write data
- mem_we  out  1  memory write enable
- mem_rdata  in  DATA_W  memory registered output

## Operation
- FSM states:
  - IDLE: sample requests; if any port wins, register mem_addr/mem_wdata/mem_we from the winner, latch gnt, go to ACCESS.
  - ACCESS: memory performs the op at the next edge; mem_we deasserted on exit; go to RESP.
  - RESP: capture mem_rdata into rdata of gnt port, pulse ack; go to IDLE.
- Arbitration applies only in IDLE with both req high. Policy is set by the macro (see Configuration). A single requester always wins.
- Misaligned (addr[1:0] != 00): the port is still granted and sequenced, but mem_we is forced 0. In RESP, ack and err both pulse and rdata is loaded with 0.
- Addresses ≥ 4 KiB are passed through unchanged; the memory aliases them. No error is raised.
- Writes complete with ack. rdata returns the value the memory outputs after the write, which equals wdata.
- Requesters must hold req, we, addr and wdata stable from assertion until ack.
- req high at the edge that ends the ack cycle counts as a new request.

## Timing
- req sampled at edge E0; memory op at E1; ack/rdata registered at E2, high for one cycle E2–E3.
- Latency is 2 cycles from sample to ack. Peak throughput is 1 access per 3 cycles.
- mem_we is high only during ACCESS, exactly one cycle per write.
- Reset values: state IDLE, all ack/err 0, rdata0/rdata1 0, mem_addr 0, mem_wdata 0, mem_we 0. Round-robin pointer is set so port 0 wins first.
- Reset mid-operation: the transaction is abandoned and no ack is issued. mem_we drops immediately (asynchronously), so no write lands at the following edge.
- Simultaneous req0/req1 with the previous winner still requesting:
  - round-robin build: the other port wins next;
  - fixed build: port 0 wins.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin. A 1-bit last-grant pointer is updated on each grant, and the non-last port wins a tie.
- DMEM_ARB_RR_EN undefined: fixed priority, port 0 always wins a tie. The pointer logic is not compiled.

## Test plan
- Port 0 write addr 0x10 data 0xDEADBEEF, then read 0x10 -> ack0 2 cycles after each sample, mem_we high exactly 1 cycle, rdata0 = 0xDEADBEEF, err0 = 0.
- req0 and req1 both held for reads at 0x0 and 0x4:
  - RR build: grants alternate 0,1,0,1;
  - fixed build: port 1 is never granted until req0 drops.
- Port 1 write to 0x6 -> ack1 and err1 pulse together, rdata1 = 0, mem_we never asserted, memory word 0x4 unchanged.
- Assert rst during ACCESS of a write to 0x20 -> no ack, mem_we low immediately, all outputs at reset values, FSM in IDLE.
- Port 0 address 0x1010 -> mem_addr = 0x1010, access completes normally (aliases word 4), err0 = 0.
- Back-to-back: req0 kept high through the ack cycle -> second grant sampled at the edge ending the ack cycle, second ack 3 cycles after the first.
